dispatch: RTL

In-order dispatch stage between the instruction queue and the back end. Each cycle it accepts at most one decoded instruction and allocates a ROB nick for it. It resolves source operands from the register file plus same-cycle CDB snooping (EX and SLB broadcasts), then holds the instruction in a one-entry buffer until the target unit (RS for ALU/branch ops, SLB for loads/stores) has room. It is the writer side of the RS `iDP_*` interface.

---
 rtl/dispatch_pkg.sv | 32 +++
 rtl/dispatch_dp_operand.sv | 27 ++
 rtl/dispatch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// Shared widths, opcode encodings and operand types for the dispatch stage.
package dispatch_pkg;

  localparam int unsigned OpBus   = 6;
  localparam int unsigned AddrBus = 32;
  localparam int unsigned ImmBus  = 32;
  localparam int unsigned NickBus = 5;
  localparam int unsigned DataBus = 32;
  localparam int unsigned RegBus  = 5;

  // Nick 0 means the operand value is already valid.
  localparam logic [NickBus-1:0] NickNone = '0;

  localparam logic [OpBus-1:0] OpAdd  = 6'd1;
  localparam logic [OpBus-1:0] OpAddi = 6'd2;
  localparam logic [OpBus-1:0] OpBeq  = 6'd3;
  localparam logic [OpBus-1:0] OpLw   = 6'd4;
  localparam logic [OpBus-1:0] OpSw   = 6'd5;

  typedef enum logic {StEmpty, StHold} dp_state_e;

  typedef struct packed {
    logic [NickBus-1:0] nick;
    logic [DataBus-1:0] dt;
  } operand_t;

  function automatic logic snoop_hit(input logic en, input logic [NickBus-1:0] bus_nick,
                                     input logic [NickBus-1:0] nick);
    return en && (nick != NickNone) && (bus_nick == nick);
  endfunction

endpackage

// File: rtl/dispatch_dp_operand.sv
// Source operand resolver: x0 forcing, then EX broadcast, then SLB broadcast.
module dispatch_dp_operand
  import dispatch_pkg::*;
(
  input  logic               zero,
  input  operand_t           src,
  input  logic               ex_en,
  input  logic [NickBus-1:0] ex_nick,
  input  logic [DataBus-1:0] ex_dt,
  input  logic               slb_en,
  input  logic [NickBus-1:0] slb_nick,
  input  logic [DataBus-1:0] slb_dt,
  output operand_t           res
);

  always_comb begin
    res = src;
    if (zero) begin
      res = '0;
    end else if (snoop_hit(ex_en, ex_nick, src.nick)) begin
      res = '{nick: NickNone, dt: ex_dt};
    end else if (snoop_hit(slb_en, slb_nick, src.nick)) begin
      res = '{nick: NickNone, dt: slb_dt};
    end
  end

endmodule

// File: rtl/dispatch.sv
// In-order dispatch: accepts one instruction per cycle into a one-entry hold buffer
// and issues it to RS or SLB once the target has room.
module dispatch
  import dispatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clr,
  input  logic               iIQ_en,
  input  logic [OpBus-1:0]   iIQ_op,
  input  logic [AddrBus-1:0] iIQ_pc,
  input  logic [ImmBus-1:0]  iIQ_imm,
  input  logic [RegBus-1:0]  iIQ_rd,
  input  logic [RegBus-1:0]  iIQ_rs1,
  input  logic [RegBus-1:0]  iIQ_rs2,
  input  logic               iIQ_is_ls,
  output logic               oIQ_ready,
  output logic [RegBus-1:0]  oREG_rs1,
  output logic [RegBus-1:0]  oREG_rs2,
  input  logic [NickBus-1:0] iREG_rs1_nick,
  input  logic [NickBus-1:0] iREG_rs2_nick,
  input  logic [DataBus-1:0] iREG_rs1_dt,
  input  logic [DataBus-1:0] iREG_rs2_dt,
  output logic               oREG_en,
  output logic [RegBus-1:0]  oREG_rd,
  output logic [NickBus-1:0] oREG_nick,
  input  logic               iROB_full,
  input  logic [NickBus-1:0] iROB_nick,
  output logic               oROB_en,
  input  logic               iRS_full,
  input  logic               iSLB_full,
  input  logic               iEX_en,
  input  logic [NickBus-1:0] iEX_nick,
  input  logic [DataBus-1:0] iEX_dt,
  input  logic               iSLB_en,
  input  logic [NickBus-1:0] iSLB_nick,
  input  logic [DataBus-1:0] iSLB_dt,
  output logic               oRS_en,
  output logic               oSLB_en,
  output logic [OpBus-1:0]   oDP_op,
  output logic [AddrBus-1:0] oDP_pc,
  output logic [ImmBus-1:0]  oDP_imm,
  output logic [NickBus-1:0] oDP_rd_nick,
  output logic [NickBus-1:0] oDP_rs1_nick,
  output logic [DataBus-1:0] oDP_rs1_dt,
  output logic [NickBus-1:0] oDP_rs2_nick,
  output logic [DataBus-1:0] oDP_rs2_dt
);

  dp_state_e          state_q;
  logic               buf_is_ls_q;
  logic [OpBus-1:0]   buf_op_q;
  logic [AddrBus-1:0] buf_pc_q;
  logic [ImmBus-1:0]  buf_imm_q;
  logic [NickBus-1:0] buf_rd_nick_q;
  operand_t           buf_rs1_q, buf_rs2_q;
  operand_t           new_rs1, new_rs2, hold_rs1, hold_rs2;
  logic               issue, accept;

  assign issue  = (state_q == StHold) && !(buf_is_ls_q ? iSLB_full : iRS_full);
  assign accept = iIQ_en && !iROB_full && ((state_q == StEmpty) || issue) && rdy && rst && !clr;

  assign oIQ_ready = accept;
  assign oROB_en   = accept;
  assign oREG_en   = accept && (iIQ_rd != '0);
  assign oREG_rs1  = rst ? iIQ_rs1 : '0;
  assign oREG_rs2  = rst ? iIQ_rs2 : '0;
  assign oREG_rd   = rst ? iIQ_rd : '0;
  assign oREG_nick = rst ? iROB_nick : '0;

  // Accept-time resolvers use the regfile's pre-rename tags, so rd==rs needs no special case.
  dispatch_dp_operand u_new_rs1 (
    .zero(iIQ_rs1 == '0), .src('{nick: iREG_rs1_nick, dt: iREG_rs1_dt}),
    .ex_en(iEX_en), .ex_nick(iEX_nick), .ex_dt(iEX_dt),
    .slb_en(iSLB_en), .slb_nick(iSLB_nick), .slb_dt(iSLB_dt), .res(new_rs1)
  );
  dispatch_dp_operand u_new_rs2 (
    .zero(iIQ_rs2 == '0), .src('{nick: iREG_rs2_nick, dt: iREG_rs2_dt}),
    .ex_en(iEX_en), .ex_nick(iEX_nick), .ex_dt(iEX_dt),
    .slb_en(iSLB_en), .slb_nick(iSLB_nick), .slb_dt(iSLB_dt), .res(new_rs2)
  );
  dispatch_dp_operand u_hold_rs1 (
    .zero(1'b0), .src(buf_rs1_q),
    .ex_en(iEX_en), .ex_nick(iEX_nick), .ex_dt(iEX_dt),
    .slb_en(iSLB_en), .slb_nick(iSLB_nick), .slb_dt(iSLB_dt), .res(hold_rs1)
  );
  dispatch_dp_operand u_hold_rs2 (
    .zero(1'b0), .src(buf_rs2_q),
    .ex_en(iEX_en), .ex_nick(iEX_nick), .ex_dt(iEX_dt),
    .slb_en(iSLB_en), .slb_nick(iSLB_nick), .slb_dt(iSLB_dt), .res(hold_rs2)
  );

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state_q       <= StEmpty;
      buf_is_ls_q   <= 1'b0;
      buf_op_q      <= '0;
      buf_pc_q      <= '0;
      buf_imm_q     <= '0;
      buf_rd_nick_q <= '0;
      buf_rs1_q     <= '0;
      buf_rs2_q     <= '0;
      oRS_en        <= 1'b0;
      oSLB_en       <= 1'b0;
      oDP_op        <= '0;
      oDP_pc        <= '0;
      oDP_imm       <= '0;
      oDP_rd_nick   <= '0;
      oDP_rs1_nick  <= '0;
      oDP_rs1_dt    <= '0;
      oDP_rs2_nick  <= '0;
      oDP_rs2_dt    <= '0;
    end else if (rdy) begin
      oRS_en  <= issue && !buf_is_ls_q;
      oSLB_en <= issue && buf_is_ls_q;
      if (issue) begin
        oDP_op       <= buf_op_q;
        oDP_pc       <= buf_pc_q;
        oDP_imm      <= buf_imm_q;
        oDP_rd_nick  <= buf_rd_nick_q;
        oDP_rs1_nick <= hold_rs1.nick;
        oDP_rs1_dt   <= hold_rs1.dt;
        oDP_rs2_nick <= hold_rs2.nick;
        oDP_rs2_dt   <= hold_rs2.dt;
      end
      if (accept) begin
        state_q       <= StHold;
        buf_is_ls_q   <= iIQ_is_ls;
        buf_op_q      <= iIQ_op;
        buf_pc_q      <= iIQ_pc;
        buf_imm_q     <= iIQ_imm;
        buf_rd_nick_q <= iROB_nick;
        buf_rs1_q     <= new_rs1;
        buf_rs2_q     <= new_rs2;
      end else if (issue) begin
        state_q <= StEmpty;
      end else begin
        buf_rs1_q <= hold_rs1;
        buf_rs2_q <= hold_rs2;
      end
    end
  end

endmodule
